// File: rtl/mips_hazard_pkg.sv
// Shared encodings for the MIPS hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// FWD_* are the forwardaE/forwardbE mux selects; div_state_t is the
// divider handshake state.
package mips_hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-to-hazard-unit signal bundle: stage register specifiers in, controls out.
// Latency: n/a (wires only).
// Backpressure: n/a; the stall outputs are the pipeline's backpressure.
//
// master: datapath side (drives the stage information, consumes the controls).
// slave : hazard unit side.
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    // D stage
    logic [REG_AW-1:0] rsD, rtD;
    logic              branchD, jrD, hilo_readD;
    // E stage
    logic [REG_AW-1:0] rsE, rtE, writeregE;
    logic              regwriteE, memtoregE, div_startE, hilo_writeE;
    // M stage
    logic [REG_AW-1:0] writeregM;
    logic              regwriteM, memtoregM, hilo_writeM, flush_excM;
    // W stage
    logic [REG_AW-1:0] writeregW;
    logic              regwriteW;
    // Controls back to the datapath
    logic              stallF, stallD, stallE;
    logic              flushD, flushE, flushM, flushW;
    logic              forwardaD, forwardbD;
    logic [1:0]        forwardaE, forwardbE;
    logic              div_busy, div_done;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output rsD, rtD, branchD, jrD, hilo_readD,
        output rsE, rtE, writeregE, regwriteE, memtoregE, div_startE, hilo_writeE,
        output writeregM, regwriteM, memtoregM, hilo_writeM, flush_excM,
        output writeregW, regwriteW,
        input  stallF, stallD, stallE, flushD, flushE, flushM, flushW,
        input  forwardaD, forwardbD, forwardaE, forwardbE,
        input  div_busy, div_done, stall_cnt
    );

    modport slave (
        input  rsD, rtD, branchD, jrD, hilo_readD,
        input  rsE, rtE, writeregE, regwriteE, memtoregE, div_startE, hilo_writeE,
        input  writeregM, regwriteM, memtoregM, hilo_writeM, flush_excM,
        input  writeregW, regwriteW,
        output stallF, stallD, stallE, flushD, flushE, flushM, flushW,
        output forwardaD, forwardbD, forwardaE, forwardbE,
        output div_busy, div_done, stall_cnt
    );

endinterface

// File: rtl/hazard_unit_mc_div_fsm.sv
// Multi-cycle divider handshake: counts DIV_CYCLES after start, then pulses done.
// Latency: hold asserted DIV_CYCLES+1 cycles from first start; done one cycle after that.
// Backpressure: hold keeps the divide in E until the DONE cycle; abort drops back to IDLE.
//
// Ports: clk, rst (sync, active-high); start (div in E), abort (exception in M);
//        busy (state != IDLE), done (state == DONE), hold (divide must stay in E).
module div_stall_fsm
    import mips_hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    output logic hold
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    div_state_t    state;
    logic [CW-1:0] cnt;

    // busy/done are registered alongside the state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (abort) begin
            // An exception kills the divide outright; no result is written.
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        cnt   <= CW'(DIV_CYCLES - 1);
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // The divide is released on the DONE cycle so it leaves E on that edge.
    assign hold = start & (state != DONE);

endmodule

// File: rtl/hazard_unit_mc.sv
// 5-stage MIPS hazard controller: stalls, flushes, forwarding, divider interlock.
// Latency: stall/flush/forward are combinational; divider adds DIV_CYCLES+1 stall cycles.
// Backpressure: asserts stallF/stallD(/stallE) and inserts bubbles via flushE/flushM.
//
// Ports: clk, rst (sync, active-high); hif (slave side of hazard_unit_mc_if).
module hazard_unit_mc
    import mips_hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32,
    parameter bit FWD_WB     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    hazard_unit_mc_if.slave        hif
);

    localparam logic [REG_AW-1:0] ZERO = '0;

    logic div_busy_q, div_done_q, div_hold;
    logic lwstall, brstall, hilostall;
    logic hit_e, hit_m;
    logic [CNT_W-1:0] stall_cnt_q;

    div_stall_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (hif.div_startE),
        .abort (hif.flush_excM),
        .busy  (div_busy_q),
        .done  (div_done_q),
        .hold  (div_hold)
    );

    // jr only reads rs, so rt participates in the hit only for compare-branches.
    always_comb begin
        hit_e = (hif.rsD == hif.writeregE) | (hif.branchD & (hif.rtD == hif.writeregE));
        hit_m = (hif.rsD == hif.writeregM) | (hif.branchD & (hif.rtD == hif.writeregM));
        lwstall = hif.memtoregE & (hif.writeregE != ZERO) &
                  ((hif.writeregE == hif.rsD) | (hif.writeregE == hif.rtD));
        brstall = (hif.branchD | hif.jrD) &
                  ((hif.regwriteE & (hif.writeregE != ZERO) & hit_e) |
                   (hif.memtoregM & (hif.writeregM != ZERO) & hit_m));
        hilostall = hif.hilo_readD & (hif.hilo_writeE | hif.hilo_writeM);
    end

    always_comb begin
        hif.stallF    = 1'b0;
        hif.stallD    = 1'b0;
        hif.stallE    = 1'b0;
        hif.flushD    = 1'b0;
        hif.flushE    = 1'b0;
        hif.flushM    = 1'b0;
        hif.flushW    = 1'b0;
        hif.forwardaD = (hif.rsD != ZERO) & (hif.rsD == hif.writeregM) & hif.regwriteM;
        hif.forwardbD = (hif.rtD != ZERO) & (hif.rtD == hif.writeregM) & hif.regwriteM;
        hif.forwardaE = FWD_NONE;
        hif.forwardbE = FWD_NONE;

        if (hif.rsE != ZERO && hif.rsE == hif.writeregM && hif.regwriteM)
            hif.forwardaE = FWD_M;
        else if (FWD_WB && hif.rsE != ZERO && hif.rsE == hif.writeregW && hif.regwriteW)
            hif.forwardaE = FWD_W;

        if (hif.rtE != ZERO && hif.rtE == hif.writeregM && hif.regwriteM)
            hif.forwardbE = FWD_M;
        else if (FWD_WB && hif.rtE != ZERO && hif.rtE == hif.writeregW && hif.regwriteW)
            hif.forwardbE = FWD_W;

        if (rst) begin
            hif.flushD    = 1'b1;
            hif.flushE    = 1'b1;
            hif.flushM    = 1'b1;
            hif.flushW    = 1'b1;
            hif.forwardaD = 1'b0;
            hif.forwardbD = 1'b0;
            hif.forwardaE = FWD_NONE;
            hif.forwardbE = FWD_NONE;
        end else if (hif.flush_excM) begin
            hif.flushD = 1'b1;
            hif.flushE = 1'b1;
            hif.flushM = 1'b1;
            hif.flushW = 1'b1;
        end else if (div_hold) begin
            // Whole front end frozen; E/M gets a bubble each held cycle.
            hif.stallF = 1'b1;
            hif.stallD = 1'b1;
            hif.stallE = 1'b1;
            hif.flushM = 1'b1;
        end else if (lwstall | brstall | hilostall) begin
            hif.stallF = 1'b1;
            hif.stallD = 1'b1;
            hif.flushE = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (hif.stallF && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    // Masked during reset so the datapath sees a clean idle divider immediately.
    assign hif.div_busy  = div_busy_q & ~rst;
    assign hif.div_done  = div_done_q & ~rst;
    assign hif.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;
    import mips_hazard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REG_AW(5), .CNT_W(32)) hif ();

    hazard_unit_mc #(
        .REG_AW(5), .DIV_CYCLES(4), .CNT_W(32), .FWD_WB(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        hif.rsD = '0; hif.rtD = '0; hif.branchD = 0; hif.jrD = 0; hif.hilo_readD = 0;
        hif.rsE = '0; hif.rtE = '0; hif.writeregE = '0; hif.regwriteE = 0;
        hif.memtoregE = 0; hif.div_startE = 0; hif.hilo_writeE = 0;
        hif.writeregM = '0; hif.regwriteM = 0; hif.memtoregM = 0;
        hif.hilo_writeM = 0; hif.flush_excM = 0;
        hif.writeregW = '0; hif.regwriteW = 0;
    endtask

    // Advance one clock edge; inputs change 1 time unit after it.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [2:0] stl, input logic [3:0] fl);
        chk({tag, "_stall"}, {29'd0, hif.stallF, hif.stallD, hif.stallE}, {29'd0, stl});
        chk({tag, "_flush"}, {28'd0, hif.flushD, hif.flushE, hif.flushM, hif.flushW}, {28'd0, fl});
    endtask

    initial begin
        clr();
        rst = 1'b1;
        #1;
        // Reset state
        #1;
        chk_ctl("rst", 3'b000, 4'b1111);
        chk("rst_fwdaE", hif.forwardaE, FWD_NONE);
        chk("rst_busy", hif.div_busy, 0);
        chk("rst_done", hif.div_done, 0);
        nxt();
        nxt();
        rst = 1'b0;
        #1;
        chk("rst_cnt", hif.stall_cnt, 0);
        chk_ctl("idle", 3'b000, 4'b0000);

        // 1: load-use
        hif.memtoregE = 1; hif.regwriteE = 1; hif.writeregE = 5'd2;
        hif.rsD = 5'd2; hif.rtD = 5'd4;
        #1;
        chk_ctl("lw", 3'b110, 4'b0100);
        nxt();
        clr();
        hif.rsD = 5'd2; hif.rtD = 5'd4;
        hif.writeregM = 5'd2; hif.regwriteM = 1; hif.memtoregM = 1;
        #1;
        chk_ctl("lw_next", 3'b000, 4'b0000);
        chk("lw_cnt", hif.stall_cnt, 1);
        nxt();
        clr();
        hif.rsE = 5'd2; hif.rtE = 5'd4; hif.writeregW = 5'd2; hif.regwriteW = 1;
        #1;
        chk("lw_fwdaE", hif.forwardaE, 2'b01);
        chk("lw_fwdbE", hif.forwardbE, 2'b00);

        // 2: M has priority over W; $0 never forwarded
        clr();
        hif.writeregM = 5'd5; hif.regwriteM = 1; hif.writeregW = 5'd5; hif.regwriteW = 1;
        hif.rsE = 5'd5;
        #1;
        chk("fwdM_prio", hif.forwardaE, 2'b10);
        hif.rsE = 5'd0; hif.rtE = 5'd0; hif.writeregM = 5'd0; hif.writeregW = 5'd0;
        hif.regwriteE = 1; hif.writeregE = 5'd0;
        #1;
        chk("fwd_r0_a", hif.forwardaE, 2'b00);
        chk("fwd_r0_b", hif.forwardbE, 2'b00);

        // 3: branch compare hazards
        clr();
        hif.branchD = 1; hif.rsD = 5'd6; hif.rtD = 5'd7;
        hif.regwriteE = 1; hif.writeregE = 5'd7;
        #1;
        chk_ctl("beq", 3'b110, 4'b0100);
        nxt();
        clr();
        hif.branchD = 1; hif.rsD = 5'd6; hif.rtD = 5'd7;
        hif.regwriteM = 1; hif.writeregM = 5'd7;
        #1;
        chk_ctl("beq_next", 3'b000, 4'b0000);
        chk("beq_fwdbD", hif.forwardbD, 1);
        chk("beq_fwdaD", hif.forwardaD, 0);
        chk("beq_cnt", hif.stall_cnt, 2);
        clr();
        hif.jrD = 1; hif.rsD = 5'd6; hif.rtD = 5'd7;
        hif.regwriteE = 1; hif.writeregE = 5'd7;
        #1;
        chk_ctl("jr_rt", 3'b000, 4'b0000);
        clr();
        hif.jrD = 1; hif.rsD = 5'd6;
        hif.memtoregM = 1; hif.regwriteM = 1; hif.writeregM = 5'd6;
        #1;
        chk_ctl("jr_ldM", 3'b110, 4'b0100);
        nxt();

        // HI/LO interlock
        clr();
        hif.hilo_readD = 1; hif.hilo_writeE = 1;
        #1;
        chk_ctl("hiloE", 3'b110, 4'b0100);
        nxt();
        hif.hilo_writeE = 0; hif.hilo_writeM = 1;
        #1;
        chk_ctl("hiloM", 3'b110, 4'b0100);
        nxt();
        clr();
        #1;
        chk("hilo_cnt", hif.stall_cnt, 5);

        // 4: divide, DIV_CYCLES=4; mfhi in D is masked by the divide stall
        hif.div_startE = 1; hif.hilo_readD = 1;
        #1;
        chk_ctl("div_c0", 3'b111, 4'b0010);
        chk("div_c0_busy", hif.div_busy, 0);
        nxt();
        for (int c = 1; c <= 4; c++) begin
            chk_ctl($sformatf("div_c%0d", c), 3'b111, 4'b0010);
            chk($sformatf("div_c%0d_busy", c), hif.div_busy, 1);
            chk($sformatf("div_c%0d_done", c), hif.div_done, 0);
            nxt();
        end
        chk_ctl("div_done_cyc", 3'b000, 4'b0000);
        chk("div_done", hif.div_done, 1);
        chk("div_done_busy", hif.div_busy, 1);
        chk("div_cnt", hif.stall_cnt, 10);
        nxt();
        hif.hilo_readD = 0;
        #1;
        chk("div2_busy0", hif.div_busy, 0);
        chk("div2_done0", hif.div_done, 0);
        chk_ctl("div2_c0", 3'b111, 4'b0010);
        nxt();
        chk("div2_busy", hif.div_busy, 1);
        nxt();

        // 5: exception while BUSY (cnt=2)
        hif.flush_excM = 1;
        #1;
        chk_ctl("exc", 3'b000, 4'b1111);
        nxt();
        clr();
        #1;
        chk("exc_busy", hif.div_busy, 0);
        chk("exc_done", hif.div_done, 0);
        chk("exc_cnt", hif.stall_cnt, 12);
        nxt();
        chk("exc_done2", hif.div_done, 0);

        // 6: mfhi/mthi stall, then reset in the middle of a divide
        hif.hilo_readD = 1; hif.hilo_writeE = 1;
        #1;
        chk_ctl("mfhi", 3'b110, 4'b0100);
        nxt();
        clr();
        hif.div_startE = 1;
        nxt();
        nxt();
        chk("pre_rst_busy", hif.div_busy, 1);
        chk("pre_rst_cnt", hif.stall_cnt, 15);
        rst = 1'b1;
        #1;
        chk_ctl("mid_rst", 3'b000, 4'b1111);
        chk("mid_rst_busy", hif.div_busy, 0);
        nxt();
        rst = 1'b0;
        hif.div_startE = 0;
        #1;
        chk("post_rst_cnt", hif.stall_cnt, 0);
        chk("post_rst_busy", hif.div_busy, 0);
        chk("post_rst_done", hif.div_done, 0);
        chk_ctl("post_rst", 3'b000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
